// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU timer peripheral: state encoding and default sizing.
package mcu_pkg;

  localparam int TIMER_W        = 16;
  localparam int TIMER_PRESCALE = 4;
  localparam int TIMER_PS_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: counts 0..PRESCALE-1 while enabled and flags the last step as a tick.
module timer_prescaler
  import mcu_pkg::*;
#(
  parameter int PRESCALE = TIMER_PRESCALE,
  parameter int PS_W     = TIMER_PS_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt;

  assign tick = en && (ps_cnt == PS_LAST);

  // Holding (en low) keeps the phase, so a paused timer resumes mid-tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_cnt <= '0;
    end else if (clr) begin
      ps_cnt <= '0;
    end else if (en) begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mcu_timer.sv
// Down-counting timer with auto-reload, one-cycle expiry interrupt and count snapshot read.
// Build option: define TIMER_ONESHOT_EN to stop in DONE after each expiry instead of auto-reloading.
module mcu_timer
  import mcu_pkg::*;
#(
  parameter int WIDTH    = TIMER_W,
  parameter int PRESCALE = TIMER_PRESCALE,
  parameter int PS_W     = TIMER_PS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_cs,
  input  logic             timer_wr,
  input  logic             timer_start,
  input  logic             timer_rd,
  input  logic [WIDTH-1:0] timer_datain,
  output logic [WIDTH-1:0] timer_value,
  output logic             timer_INT,
  output logic             timer_busy
);

  timer_state_t     state, state_nxt;
  logic [WIDTH-1:0] count, reload;
  logic             wr_q;
  logic             wr_e, run_e, rd_e;
  logic             load, count_en, tick, expire;

  assign wr_e  = timer_cs & timer_wr;
  assign run_e = timer_cs & timer_start;
  assign rd_e  = timer_cs & timer_rd;

  // A load wins over a tick/expiry in the same cycle, so it also gates counting.
  assign load     = wr_e & ~wr_q;
  assign count_en = (state == RUN) && run_e && !load;
  assign expire   = tick && (count == WIDTH'(1));

  assign timer_busy = (state == RUN);

  timer_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (count_en),
    .clr  (load),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of a combinational block is given a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = ARMED;
    end else begin
      unique case (state)
        IDLE:  state_nxt = IDLE;
        ARMED: if (run_e) state_nxt = RUN;
        RUN: begin
          if (!run_e) begin
            state_nxt = ARMED;
          end else if (expire) begin
`ifdef TIMER_ONESHOT_EN
            state_nxt = DONE;
`else
            state_nxt = RUN;
`endif
          end
        end
`ifdef TIMER_ONESHOT_EN
        DONE:  if (!run_e) state_nxt = ARMED;
`else
        DONE:  state_nxt = ARMED;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      reload      <= '0;
      wr_q        <= 1'b0;
      timer_value <= '0;
      timer_INT   <= 1'b0;
    end else begin
      wr_q      <= wr_e;
      timer_INT <= expire;
      if (rd_e) timer_value <= count;
      if (load) begin
        reload <= timer_datain;
        count  <= timer_datain;
      end else if (tick) begin
        count <= expire ? reload : count - 1'b1;
      end
    end
  end

endmodule
